cpu_step_sequencer: RTL and testbench



---
 rtl/cpu_step_sequencer_pkg.sv | 15 +
 rtl/cpu_step_sequencer_if.sv | 40 ++++
 rtl/cpu_step_sequencer_onehot_dec.sv | 21 ++
 rtl/cpu_step_sequencer.sv | 104 ++++++++++
 tb/tb_cpu_step_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_sequencer_pkg.sv
// Shared control-unit definitions for the Simple CPU step sequencer:
// FSM state encoding, step code / one-hot widths and default step count.
package cpu_ctrl_pkg;

  localparam int STEP_CODE_W   = 5;
  localparam int STEP_ONEHOT_W = 20;
  localparam int NUM_STEPS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } step_state_e;

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// Handshake bundle between the control logic and the step sequencer.
// Optional debug single-step input step_en exists only when STEP_SINGLE_EN
// is defined.
interface cpu_step_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic                     start;
  logic                     done;
  logic                     stall;
  logic                     halt;
`ifdef STEP_SINGLE_EN
  logic                     step_en;
`endif
  logic [STEP_CODE_W-1:0]   step_code;
  logic [STEP_ONEHOT_W-1:0] step_onehot;
  logic                     busy;
  logic                     instr_done;
  logic                     overrun;

`ifdef STEP_SINGLE_EN
  modport master (
    output start, done, stall, halt, step_en,
    input  step_code, step_onehot, busy, instr_done, overrun
  );
  modport slave (
    input  start, done, stall, halt, step_en,
    output step_code, step_onehot, busy, instr_done, overrun
  );
`else
  modport master (
    output start, done, stall, halt,
    input  step_code, step_onehot, busy, instr_done, overrun
  );
  modport slave (
    input  start, done, stall, halt,
    output step_code, step_onehot, busy, instr_done, overrun
  );
`endif

endinterface

// File: rtl/cpu_step_sequencer_onehot_dec.sv
// Step code to one-hot row-select decoder. Rows at or above NUM_STEPS never
// light, and the whole vector is zero while disabled.
module step_onehot_dec #(
  parameter int NUM_STEPS = 10,
  parameter int CODE_W    = 5,
  parameter int ONEHOT_W  = 20
) (
  input  logic [CODE_W-1:0]   code,
  input  logic                en,
  output logic [ONEHOT_W-1:0] onehot
);

  // Compare against every row index so out-of-range codes simply match nothing.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      onehot[i] = en && (i < NUM_STEPS) && (code == CODE_W'(i));
    end
  end

endmodule

// File: rtl/cpu_step_sequencer.sv
// Microstep timing generator for the Simple CPU control unit.
// Optional feature macro: STEP_SINGLE_EN (adds bus.step_en for debug
// single-stepping; with it undefined the counter advances every
// non-stalled cycle).
//
// state | meaning
// IDLE  | no instruction in flight, waiting for start
// RUN   | stepping through microsteps
// STALL | current step held (stall or, when single-stepping, no step_en)
module cpu_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int CODE_W    = STEP_CODE_W,
  parameter int ONEHOT_W  = STEP_ONEHOT_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  cpu_step_sequencer_if.slave  bus
);

  localparam logic [CODE_W-1:0] LAST_STEP = CODE_W'(NUM_STEPS - 1);

  step_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              instr_done_q, instr_done_d;
  logic              overrun_q, overrun_d;
  logic              hold;
  logic              busy;

`ifdef STEP_SINGLE_EN
  assign hold = bus.stall || !bus.step_en;
`else
  assign hold = bus.stall;
`endif

  // State, step counter and status flags.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      code_q       <= '0;
      instr_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      instr_done_q <= instr_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next state: halt > done (or forced end at last step) > stall > advance.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    instr_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        code_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN, STALL: begin
        if (bus.halt) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (bus.done || code_q == LAST_STEP) begin
          // Forced end at the last step counts as an overrun.
          if (!bus.done) overrun_d = 1'b1;
          instr_done_d = 1'b1;
          code_d       = '0;
          state_d      = bus.start ? RUN : IDLE;
        end else if (hold) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
          code_d  = code_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == STALL);

  step_onehot_dec #(
    .NUM_STEPS (NUM_STEPS),
    .CODE_W    (CODE_W),
    .ONEHOT_W  (ONEHOT_W)
  ) u_dec (
    .code   (code_q),
    .en     (busy),
    .onehot (bus.step_onehot)
  );

  assign bus.step_code  = code_q;
  assign bus.busy       = busy;
  assign bus.instr_done = instr_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, so each tick shows the
// registered response to the inputs set before it.
module tb_cpu_step_sequencer;
  import cpu_ctrl_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cpu_step_sequencer_if bus ();

  cpu_step_sequencer #(.NUM_STEPS(10)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_instr();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (bus.step_code !== 5'd0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: code=%0d busy=%0b overrun=%0b expected 0/0/0",
               bus.step_code, bus.busy, bus.overrun);
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.step_code !== 5'd0 || bus.step_onehot !== 20'd0 ||
          bus.busy !== 1'b0 || bus.instr_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d: code=%0d onehot=%h busy=%0b done=%0b expected 0/0/0/0",
                 i, bus.step_code, bus.step_onehot, bus.busy, bus.instr_done);
      end
    end
  endtask

  task automatic test_basic();
    start_instr();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.step_code !== 5'(i) || bus.step_onehot !== (20'd1 << i) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_step%0d: code=%0d onehot=%h busy=%0b expected %0d/%h/1",
                 i, bus.step_code, bus.step_onehot, bus.busy, i, 20'd1 << i);
      end
      if (i == 3) bus.done = 1'b1;
      tick();
    end
    bus.done = 1'b0;
    checks++;
    if (bus.instr_done !== 1'b1 || bus.busy !== 1'b0 || bus.step_code !== 5'd0) begin
      errors++;
      $display("FAIL basic_end: instr_done=%0b busy=%0b code=%0d expected 1/0/0",
               bus.instr_done, bus.busy, bus.step_code);
    end
    tick();
    checks++;
    if (bus.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: instr_done=%0b expected 0", bus.instr_done);
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.step_code !== 5'(k % 3) || bus.busy !== 1'b1 ||
          bus.instr_done !== (k == 3)) begin
        errors++;
        $display("FAIL b2b_%0d: code=%0d busy=%0b instr_done=%0b expected %0d/1/%0b",
                 k, bus.step_code, bus.busy, bus.instr_done, k % 3, k == 3);
      end
      bus.done = (k % 3 == 2);
      tick();
    end
    bus.done  = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.step_code !== 5'd0 || bus.busy !== 1'b1 || bus.instr_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_end: code=%0d busy=%0b instr_done=%0b expected 0/1/1",
               bus.step_code, bus.busy, bus.instr_done);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_halt: busy=%0b instr_done=%0b expected 0/0", bus.busy, bus.instr_done);
    end
  endtask

  task automatic test_stall();
    start_instr();
    repeat (4) tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.step_code !== 5'd4 || bus.step_onehot !== 20'd16 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: code=%0d onehot=%h busy=%0b expected 4/10/1",
                 i, bus.step_code, bus.step_onehot, bus.busy);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.step_code !== 5'd5 || bus.step_onehot !== 20'd32) begin
      errors++;
      $display("FAIL stall_release: code=%0d onehot=%h expected 5/20",
               bus.step_code, bus.step_onehot);
    end
    bus.stall = 1'b1;
    bus.done  = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    checks++;
    if (bus.instr_done !== 1'b1 || bus.busy !== 1'b0 || bus.step_code !== 5'd0) begin
      errors++;
      $display("FAIL stall_done: instr_done=%0b busy=%0b code=%0d expected 1/0/0",
               bus.instr_done, bus.busy, bus.step_code);
    end
    tick();
  endtask

  task automatic test_overrun();
    start_instr();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.step_code !== 5'(i) || bus.overrun !== 1'b0) begin
        errors++;
        $display("FAIL ovr_step%0d: code=%0d overrun=%0b expected %0d/0",
                 i, bus.step_code, bus.overrun, i);
      end
      if (i == 9) begin
        checks++;
        if (bus.step_onehot !== 20'd512) begin
          errors++;
          $display("FAIL ovr_last_onehot: onehot=%h expected 200", bus.step_onehot);
        end
      end
      tick();
    end
    checks++;
    if (bus.instr_done !== 1'b1 || bus.overrun !== 1'b1 || bus.busy !== 1'b0 ||
        bus.step_code !== 5'd0) begin
      errors++;
      $display("FAIL ovr_end: instr_done=%0b overrun=%0b busy=%0b code=%0d expected 1/1/0/0",
               bus.instr_done, bus.overrun, bus.busy, bus.step_code);
    end
    tick();
    start_instr();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.instr_done !== 1'b1 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: instr_done=%0b overrun=%0b expected 1/1",
               bus.instr_done, bus.overrun);
    end
    tick();
  endtask

  task automatic test_halt_and_reset();
    start_instr();
    repeat (6) tick();
    checks++;
    if (bus.step_code !== 5'd6) begin
      errors++;
      $display("FAIL halt_pre: code=%0d expected 6", bus.step_code);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.step_code !== 5'd0 || bus.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL halt: busy=%0b code=%0d instr_done=%0b expected 0/0/0",
               bus.busy, bus.step_code, bus.instr_done);
    end
    tick();
    checks++;
    if (bus.instr_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_after: instr_done=%0b busy=%0b expected 0/0", bus.instr_done, bus.busy);
    end
    start_instr();
    repeat (6) tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.step_code !== 5'd0 || bus.busy !== 1'b0 || bus.step_onehot !== 20'd0 ||
        bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: code=%0d busy=%0b onehot=%h overrun=%0b expected 0/0/0/0",
               bus.step_code, bus.busy, bus.step_onehot, bus.overrun);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.instr_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: instr_done=%0b busy=%0b expected 0/0", bus.instr_done, bus.busy);
    end
  endtask

`ifdef STEP_SINGLE_EN
  task automatic test_single_step();
    bus.step_en = 1'b0;
    start_instr();
    repeat (2) tick();
    checks++;
    if (bus.step_code !== 5'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL sstep_idle: code=%0d busy=%0b expected 0/1", bus.step_code, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.step_en = 1'b1;
      tick();
      bus.step_en = 1'b0;
      tick();
    end
    checks++;
    if (bus.step_code !== 5'd3) begin
      errors++;
      $display("FAIL sstep_three: code=%0d expected 3", bus.step_code);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt    = 1'b0;
    bus.step_en = 1'b1;
    tick();
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.done  = 1'b0;
    bus.stall = 1'b0;
    bus.halt  = 1'b0;
`ifdef STEP_SINGLE_EN
    bus.step_en = 1'b1;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_halt_and_reset();
`ifdef STEP_SINGLE_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
